// File: rtl/cmp_pkg.sv
// ============================================================================
// Module   : cmp_pkg
// Purpose  : Shared types and limits for the comparator debounce slice.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cmp_pkg;

   typedef enum logic [1:0] {
      CMP_UNKNOWN = 2'd0,
      CMP_LESS    = 2'd1,
      CMP_EQUAL   = 2'd2,
      CMP_GREATER = 2'd3
   } cmp_state_t;

   localparam int CMP_PERSIST_MAX = 15;

endpackage : cmp_pkg

`default_nettype wire

// File: rtl/cmp_flag_decode.sv
// ============================================================================
// Module   : cmp_flag_decode
// Purpose  : Maps comparator less/equal/greater flags to a state code and a
//            legal bit (legal only when exactly one flag is high).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cmp_flag_decode
   import cmp_pkg::*;
(
   input  logic       less,
   input  logic       equal,
   input  logic       greater,
   output cmp_state_t code,
   output logic       legal
);

   always_comb begin
      code  = CMP_UNKNOWN;
      legal = 1'b0;
      case ({less, equal, greater})
         3'b100: begin
            code  = CMP_LESS;
            legal = 1'b1;
         end
         3'b010: begin
            code  = CMP_EQUAL;
            legal = 1'b1;
         end
         3'b001: begin
            code  = CMP_GREATER;
            legal = 1'b1;
         end
         default: begin
            code  = CMP_UNKNOWN;
            legal = 1'b0;
         end
      endcase
   end

endmodule : cmp_flag_decode

`default_nettype wire

// File: rtl/cmp_debounce.sv
// ============================================================================
// Module   : cmp_debounce
// Purpose  : Debounces comparator flags into a stable accepted state, with a
//            change pulse, a change counter and a sticky illegal-flag error.
//            The counter exists only when CMP_DEBOUNCE_COUNT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cmp_debounce
   import cmp_pkg::*;
#(
   parameter int PERSIST = 4,
   parameter int CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic             less,
   input  logic             equal,
   input  logic             greater,
   input  logic             clear,
   output logic [1:0]       state_o,
   output logic             stable,
   output logic             change_pulse,
   output logic [CNT_W-1:0] change_count,
   output logic             error
);

   // Out-of-range PERSIST is clamped into 1..CMP_PERSIST_MAX so the 4-bit run fits.
   localparam int         c_persist_int = (PERSIST < 1) ? 1 :
                                          (PERSIST > CMP_PERSIST_MAX) ? CMP_PERSIST_MAX : PERSIST;
   localparam logic [3:0] c_persist     = 4'(c_persist_int);

   cmp_state_t w_code;
   logic       w_legal;

   cmp_state_t r_cand;
   logic [3:0] r_run;
   cmp_state_t r_state;
   logic       r_stable;
   logic       r_pulse;
   logic       r_error;

   cmp_state_t w_cand_nxt;
   logic [3:0] w_run_nxt;
   logic       w_accept;
   logic       w_accept_change;

   cmp_flag_decode u_decode (
      .less    (less),
      .equal   (equal),
      .greater (greater),
      .code    (w_code),
      .legal   (w_legal)
   );

   always_comb begin
      w_cand_nxt = r_cand;
      w_run_nxt  = r_run;
      if (in_valid) begin
         if (!w_legal) begin
            w_run_nxt = 4'd0;
         end else if (w_code == r_cand) begin
            w_run_nxt = (r_run >= c_persist) ? c_persist : r_run + 4'd1;
         end else begin
            w_cand_nxt = w_code;
            w_run_nxt  = 4'd1;
         end
      end
   end

   assign w_accept        = in_valid && w_legal && (w_run_nxt == c_persist)
                            && (w_cand_nxt != r_state);
   assign w_accept_change = w_accept && (r_state != CMP_UNKNOWN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cand   <= CMP_UNKNOWN;
         r_run    <= 4'd0;
         r_state  <= CMP_UNKNOWN;
         r_stable <= 1'b0;
         r_pulse  <= 1'b0;
         r_error  <= 1'b0;
      end else if (clear) begin
         r_cand   <= CMP_UNKNOWN;
         r_run    <= 4'd0;
         r_state  <= CMP_UNKNOWN;
         r_stable <= 1'b0;
         r_pulse  <= 1'b0;
         r_error  <= 1'b0;
      end else begin
         r_cand  <= w_cand_nxt;
         r_run   <= w_run_nxt;
         r_pulse <= w_accept_change;
         if (w_accept) begin
            r_state  <= w_cand_nxt;
            r_stable <= 1'b1;
         end
         if (in_valid && !w_legal) begin
            r_error <= 1'b1;
         end
      end
   end

`ifdef CMP_DEBOUNCE_COUNT_EN
   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (clear) begin
         r_count <= '0;
      end else if (w_accept_change) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign change_count = r_count;
`else
   assign change_count = '0;
`endif

   assign state_o      = r_state;
   assign stable       = r_stable;
   assign change_pulse = r_pulse;
   assign error        = r_error;

endmodule : cmp_debounce

`default_nettype wire
